// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM state encoding and the default size and wait-state count.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int DMEM_DEPTH_DEFAULT = 256;
  localparam int DMEM_WAIT_DEFAULT  = 2;

endpackage

// File: rtl/dmem_array.sv
// 1R1W word array: synchronous write, combinational read, no reset.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module dmem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage; DMEM_WAIT_STATES_EN adds a
// WAIT-cycle IDLE/BUSY/DONE handshake, otherwise access is single-cycle.
// Ports: clk, reset (async low), req_valid_M, memwrite_M, addr_M,
// writedata_M in; readdata_M, stall_M, misalign_M out.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int WAIT  = DMEM_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_M,
  input  logic        memwrite_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] writedata_M,
  output logic [31:0] readdata_M,
  output logic        stall_M,
  output logic        misalign_M
);

  localparam int AW = $clog2(DEPTH);

  logic          we;
  logic [AW-1:0] idx;
  logic [31:0]   wd;
  logic [31:0]   rdata;
  logic          unused_hi;

  // upper address bits fall outside the array and simply wrap
  assign unused_hi = ^addr_M[31:AW+2];

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(idx),
    .wdata(wd),
    .raddr(idx),
    .rdata(rdata)
  );

`ifdef DMEM_WAIT_STATES_EN

  localparam logic [3:0] WaitCnt = 4'(WAIT);

  dmem_state_e   state;
  logic [3:0]    cnt;
  logic [AW+1:0] a_addr;
  logic          a_we;
  logic [31:0]   a_wd;
  logic          in_idle;
  logic [AW+1:0] x_addr;
  logic          x_we;
  logic          x_mis;
  logic          go_done;

  // in IDLE the live inputs are used so WAIT=0 can finish next edge
  assign in_idle = (state == IDLE);
  assign x_addr  = in_idle ? addr_M[AW+1:0] : a_addr;
  assign x_we    = in_idle ? memwrite_M : a_we;
  assign wd      = in_idle ? writedata_M : a_wd;
  assign x_mis   = |x_addr[1:0];
  assign idx     = x_addr[AW+1:2];

  assign go_done = reset &
    ((in_idle & req_valid_M & (WaitCnt == 4'd0)) |
     ((state == BUSY) & (cnt == 4'd1)));

  assign we      = go_done & x_we & ~x_mis;
  assign stall_M = reset &
    ((in_idle & req_valid_M) | (state == BUSY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      a_addr     <= '0;
      a_we       <= 1'b0;
      a_wd       <= '0;
      readdata_M <= '0;
      misalign_M <= 1'b0;
    end else begin
      misalign_M <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_M) begin
            a_addr <= addr_M[AW+1:0];
            a_we   <= memwrite_M;
            a_wd   <= writedata_M;
            cnt    <= WaitCnt;
            state  <= (WaitCnt == 4'd0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (go_done) begin
        readdata_M <= x_mis ? 32'd0 : rdata;
        misalign_M <= x_mis;
      end
    end
  end

`else

  logic       mis;
  logic [3:0] unused_wait;

  assign unused_wait = 4'(WAIT);
  assign mis         = |addr_M[1:0];
  assign idx         = addr_M[AW+1:2];
  assign wd          = writedata_M;
  assign we          = reset & req_valid_M & memwrite_M & ~mis;
  assign stall_M     = 1'b0;
  assign misalign_M  = reset & req_valid_M & mis;
  assign readdata_M  = (reset & ~mis) ? rdata : 32'd0;

`endif

endmodule
